// File: rtl/rr_pkt_arb_2ch_if.sv
// Handshake bundle for the two-channel packet arbiter: two source channels in, one stream out.
// A beat moves on a channel in any cycle where its valid and ready are both high at the rising edge.
interface rr_pkt_arb_2ch_if #(
    parameter int DATA_W = 8
);
    logic              v0;
    logic [DATA_W-1:0] d0;
    logic              last0;
    logic              rdy0;
    logic              v1;
    logic [DATA_W-1:0] d1;
    logic              last1;
    logic              rdy1;
    logic              sel;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              out_ready;

    modport master (
        output v0, d0, last0, v1, d1, last1, out_ready,
        input  rdy0, rdy1, sel, out_valid, out_data, out_last
    );

    modport slave (
        input  v0, d0, last0, v1, d1, last1, out_ready,
        output rdy0, rdy1, sel, out_valid, out_data, out_last
    );
endinterface

// File: rtl/rr_pkt_arb_2ch.sv
// Two-channel round-robin packet arbiter: drives the 2:1 mux select, locks a channel for a
// whole packet and registers the chosen beat into a single output stage.
module rr_pkt_arb_2ch #(
    parameter int DATA_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    rr_pkt_arb_2ch_if.slave      bus,
    output logic [1:0]           state_dbg,
    output logic                 prio_dbg
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              prio_q, prio_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_last_q, out_last_d;

    logic              load;
    logic              sel_c;
    logic              rdy0_c, rdy1_c;
    logic              xfer;
    logic [DATA_W-1:0] mux_data;
    logic              mux_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            prio_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        sel_c       = prio_q;
        rdy0_c      = 1'b0;
        rdy1_c      = 1'b0;

        // The output stage can take a beat when empty or when its current beat leaves now.
        load = bus.out_ready | ~out_valid_q;

        case (state_q)
            LOCK0: begin
                sel_c  = 1'b0;
                rdy0_c = load;
            end
            LOCK1: begin
                sel_c  = 1'b1;
                rdy1_c = load;
            end
            default: begin
                if (bus.v0 && bus.v1) sel_c = prio_q;
                else if (bus.v0)      sel_c = 1'b0;
                else if (bus.v1)      sel_c = 1'b1;
                else                  sel_c = prio_q;
                rdy0_c = load & bus.v0 & ~sel_c;
                rdy1_c = load & bus.v1 & sel_c;
            end
        endcase

        // Nothing is accepted while reset is held, even though the IDLE decode would allow it.
        if (rst) begin
            rdy0_c = 1'b0;
            rdy1_c = 1'b0;
        end

        mux_data = sel_c ? bus.d1 : bus.d0;
        mux_last = sel_c ? bus.last1 : bus.last0;
        xfer     = sel_c ? (bus.v1 & rdy1_c) : (bus.v0 & rdy0_c);

        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = mux_data;
            out_last_d  = mux_last;
            if (mux_last) begin
                state_d = IDLE;
                prio_d  = ~sel_c;
            end else begin
                state_d = sel_c ? LOCK1 : LOCK0;
            end
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    assign bus.rdy0      = rdy0_c;
    assign bus.rdy1      = rdy1_c;
    assign bus.sel       = sel_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign state_dbg     = state_q;
    assign prio_dbg      = prio_q;
endmodule

// File: tb/tb_rr_pkt_arb_2ch.sv
// Directed bench for rr_pkt_arb_2ch: contention, packet lock, backpressure, bubbles, idle select
// and reset mid-packet, with an ordered scoreboard on the output stream.
module tb_rr_pkt_arb_2ch;
    localparam int DATA_W = 8;

    logic       clk;
    logic       rst;
    logic [1:0] state_dbg;
    logic       prio_dbg;

    int checks = 0;
    int errors = 0;
    logic [DATA_W:0] exp_q[$];

    rr_pkt_arb_2ch_if #(.DATA_W(DATA_W)) bus ();

    rr_pkt_arb_2ch #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .state_dbg (state_dbg),
        .prio_dbg  (prio_dbg)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive(input logic v0, input logic [7:0] d0, input logic l0,
                         input logic v1, input logic [7:0] d1, input logic l1);
        bus.v0 = v0; bus.d0 = d0; bus.last0 = l0;
        bus.v1 = v1; bus.d1 = d1; bus.last1 = l1;
    endtask

    task automatic expect_grant(input string tag, input logic s, input logic r0, input logic r1);
        settle();
        check({tag, "_sel"}, 32'(bus.sel), 32'(s));
        check({tag, "_rdy0"}, 32'(bus.rdy0), 32'(r0));
        check({tag, "_rdy1"}, 32'(bus.rdy1), 32'(r1));
    endtask

    // Scoreboard: each beat leaving the output stage must match the oldest expected beat.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", {23'd0, bus.out_last, bus.out_data}, 32'h1ff);
            end else begin
                check("out_beat", {23'd0, bus.out_last, bus.out_data}, {23'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus.out_ready = 1'b1;
        drive(1'b1, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1);
        #12;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_rdy0", 32'(bus.rdy0), 32'd0);
        check("rst_rdy1", 32'(bus.rdy1), 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        rst = 1'b0;
        tick();

        // Contention with single-beat packets alternates every cycle.
        drive(1'b1, 8'hA0, 1'b1, 1'b1, 8'hB1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            expect_grant("cont", 1'(i % 2), (i % 2) == 0, (i % 2) == 1);
            exp_q.push_back((i % 2) == 0 ? 9'h1A0 : 9'h1B1);
            tick();
        end
        check("cont_prio", 32'(prio_dbg), 32'd0);
        drive(1'b1, 8'hC0, 1'b1, 1'b0, 8'h00, 1'b0);
        expect_grant("lone0", 1'b0, 1'b1, 1'b0);
        exp_q.push_back(9'h1C0);
        tick();
        check("lone0_prio", 32'(prio_dbg), 32'd1);

        // Channel 1 holds the lock for three beats while channel 0 keeps asking.
        drive(1'b1, 8'h55, 1'b1, 1'b1, 8'h11, 1'b0);
        expect_grant("lock_b0", 1'b1, 1'b0, 1'b1);
        exp_q.push_back(9'h011);
        tick();
        check("lock_state", 32'(state_dbg), 32'd2);
        drive(1'b1, 8'h55, 1'b1, 1'b1, 8'h12, 1'b0);
        expect_grant("lock_b1", 1'b1, 1'b0, 1'b1);
        exp_q.push_back(9'h012);
        tick();
        drive(1'b1, 8'h55, 1'b1, 1'b1, 8'h13, 1'b1);
        expect_grant("lock_b2", 1'b1, 1'b0, 1'b1);
        exp_q.push_back(9'h113);
        tick();
        check("lock_prio", 32'(prio_dbg), 32'd0);
        check("lock_idle", 32'(state_dbg), 32'd0);
        drive(1'b1, 8'h55, 1'b1, 1'b0, 8'h00, 1'b0);
        expect_grant("after_lock", 1'b0, 1'b1, 1'b0);
        exp_q.push_back(9'h155);
        tick();

        // Backpressure: beat 55 sits in the output stage for four cycles.
        bus.out_ready = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b1, 8'h66, 1'b1);
        for (int i = 0; i < 4; i++) begin
            expect_grant("stall", 1'b1, 1'b0, 1'b0);
            check("stall_valid", 32'(bus.out_valid), 32'd1);
            check("stall_data", 32'(bus.out_data), 32'h55);
            check("stall_last", 32'(bus.out_last), 32'd1);
            tick();
        end
        bus.out_ready = 1'b1;
        expect_grant("release", 1'b1, 1'b0, 1'b1);
        exp_q.push_back(9'h166);
        tick();
        check("release_data", 32'(bus.out_data), 32'h66);
        check("release_valid", 32'(bus.out_valid), 32'd1);

        // Mid-packet bubble on channel 0 keeps channel 1 waiting.
        drive(1'b1, 8'h01, 1'b0, 1'b1, 8'h77, 1'b1);
        expect_grant("bub_b0", 1'b0, 1'b1, 1'b0);
        exp_q.push_back(9'h001);
        tick();
        check("bub_state", 32'(state_dbg), 32'd1);
        drive(1'b0, 8'h00, 1'b0, 1'b1, 8'h77, 1'b1);
        for (int i = 0; i < 2; i++) begin
            expect_grant("bubble", 1'b0, 1'b1, 1'b0);
            tick();
        end
        drive(1'b1, 8'h02, 1'b1, 1'b1, 8'h77, 1'b1);
        expect_grant("bub_b1", 1'b0, 1'b1, 1'b0);
        exp_q.push_back(9'h102);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b1, 8'h77, 1'b1);
        expect_grant("bub_ch1", 1'b1, 1'b0, 1'b1);
        exp_q.push_back(9'h177);
        tick();

        // Idle select follows the pointer; a lone request is granted at once.
        drive(1'b1, 8'h88, 1'b1, 1'b0, 8'h00, 1'b0);
        expect_grant("idle_pre", 1'b0, 1'b1, 1'b0);
        exp_q.push_back(9'h188);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        expect_grant("idle_none", 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        check("idle_no_valid", 32'(bus.out_valid), 32'd0);
        check("idle_sel", 32'(bus.sel), 32'd1);
        drive(1'b1, 8'h99, 1'b1, 1'b0, 8'h00, 1'b0);
        expect_grant("idle_lone", 1'b0, 1'b1, 1'b0);
        exp_q.push_back(9'h199);
        tick();
        check("idle_lone_data", 32'(bus.out_data), 32'h99);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        tick();

        // Reset in the middle of a channel 1 packet drops the held beat.
        bus.out_ready = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b1, 8'hC1, 1'b0);
        tick();
        check("pre_rst_state", 32'(state_dbg), 32'd2);
        check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        drive(1'b1, 8'hD0, 1'b1, 1'b1, 8'hC2, 1'b1);
        rst = 1'b1;
        settle();
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_rdy0", 32'(bus.rdy0), 32'd0);
        check("mid_rst_rdy1", 32'(bus.rdy1), 32'd0);
        check("mid_rst_state", 32'(state_dbg), 32'd0);
        check("mid_rst_prio", 32'(prio_dbg), 32'd0);
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        expect_grant("post_rst", 1'b0, 1'b1, 1'b0);
        exp_q.push_back(9'h1D0);
        tick();
        check("post_rst_data", 32'(bus.out_data), 32'hD0);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        tick();
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rr_pkt_arb_2ch.md
Name: rr_pkt_arb_2ch

Overview:
Two-channel round-robin packet arbiter that generates the select for the team's 2:1 data mux and registers the muxed beat into one output stage. Sits directly upstream of the mux/consumer path. Two valid/ready packet sources enter, one valid/ready packet stream leaves. A packet is locked to its channel from first beat to last, so packets never interleave.

Parameters:
DATA_W, 8, width of each data beat

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset, asynchronous, active-high
v0  input  1  channel 0 beat valid
d0  input  DATA_W  channel 0 beat data
last0  input  1  channel 0 beat is end of packet
rdy0  output  1  channel 0 beat accepted this cycle (combinational)
v1  input  1  channel 1 beat valid
d1  input  DATA_W  channel 1 beat data
last1  input  1  channel 1 beat is end of packet
rdy1  output  1  channel 1 beat accepted this cycle (combinational)
sel  output  1  mux select: 0 = channel 0, 1 = channel 1 (combinational)
out_valid  output  1  output beat valid (registered)
out_data  output  DATA_W  output beat data (registered)
out_last  output  1  output beat end of packet (registered)
out_ready  input  1  downstream accepts output beat

Behaviour:
- Clock/reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: state=IDLE, prio=0, out_valid=0, out_data=0, out_last=0. rdy0=rdy1=0 while rst high.
- load = out_ready | ~out_valid. The output register accepts a new beat only when load=1.
- FSM states: IDLE, LOCK0, LOCK1. prio is a 1-bit round-robin pointer naming the channel favoured on the next contention.
- IDLE channel choice c:
  - v0&v1: c=prio.
  - Only one valid: c = that channel.
  - None valid: c=prio, no transfer.
- IDLE transfer: rdy_c = load & v_c; other rdy=0. On transfer, the beat (d_c, last_c) loads into the output register.
  - last_c=1: stay IDLE, prio <= ~c.
  - last_c=0: go to LOCKc; prio unchanged.
- LOCKc:
  - sel=c; rdy_c = load; other channel rdy=0 regardless of its valid.
  - Transfer when v_c & rdy_c.
  - Transfer with last_c=1: go to IDLE, prio <= ~c. Otherwise stay in LOCKc.
  - v_c=0 (bubble mid-packet): stay locked and wait; no timeout.
- sel always equals the channel rdy is driven for. In IDLE with no valid, sel=prio.
- Output register, on each clock edge:
  - Transfer: out_valid<=1, out_data<=mux result, out_last<=chosen last.
  - No transfer, out_ready=1: out_valid<=0; out_data/out_last hold.
  - out_valid=1 & out_ready=0: all hold (stall). Inputs see rdy=0.
- Latency: 1 cycle from input transfer to out_valid. Throughput: 1 beat/cycle when out_ready stays high.
- Fairness: under continuous contention, packets alternate channels. Single-beat packets alternate every cycle.
- Async reset mid-packet: lock and pointer clear and the output beat is dropped. Sources must restart packets after reset.
- A source must hold v/data/last stable until accepted; the block does not check this.

Test Plan:
- Reset: assert rst mid-LOCK1 with out_valid=1 -> immediately out_valid=0, rdy0=rdy1=0; after release, state IDLE, prio=0, and the first contention is granted to ch0.
- Contention, single-beat packets: v0=v1=1, last0=last1=1, d0=8'hA0, d1=8'hB1, out_ready=1 -> out_data sequence A0,B1,A0,B1 on consecutive cycles, each with out_last=1; sel toggles 0,1,0,1.
- Packet lock: ch1 sends 3-beat packet 11,12,13 (last on 13) while v0=1 throughout -> rdy0=0 for all three beats; output 11,12,13 then ch0 beat; prio ends at 0 after ch1 last.
- Backpressure: out_ready=0 for 4 cycles with out_valid=1 -> out_data/out_last held, rdy0=rdy1=0; on out_ready=1, the next beat appears the following cycle with no loss or duplication.
- Mid-packet bubble: ch0 packet 01,(v0=0 for 2 cycles),02 last, v1=1 throughout -> sel stays 0, ch1 is not granted until after 02; output 01,02 then ch1 beat.
- Idle select: v0=v1=0 after a ch0 last -> no out_valid, sel=1 (prio); lone v0=1 then -> grant ch0, sel=0, beat out next cycle.
